// File: rtl/mult_share_ctrl.sv
// Round-robin sequencer that shares one start/finish multiplier among N_REQ requesters,
// returning each product with the requester's index and a watchdog error flag.
module mult_share_ctrl #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [2*WIDTH-1:0]       rsp_o,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_o,
  input  logic                     mul_finish
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [PW-1:0]        ptr_r, ptr_s;
  logic [PW-1:0]        id_r, id_s;
  logic [7:0]           timer_r, timer_s;
  logic                 seen_fin_r, seen_fin_s;
  logic [N_REQ-1:0]     gnt_r, gnt_s;
  logic                 rsp_valid_r, rsp_valid_s;
  logic [2:0]           rsp_id_r, rsp_id_s;
  logic [2*WIDTH-1:0]   rsp_o_r, rsp_o_s;
  logic                 rsp_err_r, rsp_err_s;
  logic                 busy_r, busy_s;
  logic                 mul_start_r, mul_start_s;
  logic [WIDTH-1:0]     mul_a_r, mul_a_s;
  logic [WIDTH-1:0]     mul_b_r, mul_b_s;
  logic                 found_s;
  int                   win_idx_s;
  logic                 timeout_s;

  // Round-robin winner: first set req bit at or above ptr, wrapping around.
  always_comb begin
    found_s   = 1'b0;
    win_idx_s = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found_s && req[(int'(ptr_r) + k) % N_REQ]) begin
        found_s   = 1'b1;
        win_idx_s = (int'(ptr_r) + k) % N_REQ;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Timer counts completed WAIT cycles; expiry when this cycle would reach TIMEOUT.
  assign timeout_s = (({1'b0, timer_r} + 9'd1) >= 9'(TIMEOUT));

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    id_s        = id_r;
    timer_s     = timer_r;
    seen_fin_s  = seen_fin_r;
    gnt_s       = {N_REQ{1'b0}};
    mul_start_s = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_id_s    = rsp_id_r;
    rsp_o_s     = rsp_o_r;
    rsp_err_s   = rsp_err_r;
    mul_a_s     = mul_a_r;
    mul_b_s     = mul_b_r;
    case (state_r)
      S_IDLE: begin
        if (found_s) begin
          mul_a_s            = req_a[win_idx_s*WIDTH +: WIDTH];
          mul_b_s            = req_b[win_idx_s*WIDTH +: WIDTH];
          id_s               = PW'(win_idx_s);
          gnt_s[win_idx_s]   = 1'b1;
          ptr_s              = PW'((win_idx_s + 1) % N_REQ);
          state_s            = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        mul_start_s = 1'b1;
        timer_s     = 8'd0;
        seen_fin_s  = 1'b0;
        state_s     = S_WAIT;
      end
      S_WAIT: begin
        timer_s = timer_r + 8'd1;
        // Product is registered by the multiplier as Finish drops, so capture on the fall.
        if (seen_fin_r && !mul_finish) begin
          rsp_o_s   = mul_o;
          rsp_err_s = 1'b0;
          state_s   = S_DONE;
        end else if (timeout_s) begin
          rsp_o_s   = {(2*WIDTH){1'b0}};
          rsp_err_s = 1'b1;
          state_s   = S_DONE;
        end else if (mul_finish) begin
          seen_fin_s = 1'b1;
        end else begin
          seen_fin_s = seen_fin_r;
        end
      end
      S_DONE: begin
        rsp_valid_s = 1'b1;
        rsp_id_s    = 3'(id_r);
        state_s     = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      ptr_r       <= {PW{1'b0}};
      id_r        <= {PW{1'b0}};
      timer_r     <= 8'd0;
      seen_fin_r  <= 1'b0;
      gnt_r       <= {N_REQ{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 3'd0;
      rsp_o_r     <= {(2*WIDTH){1'b0}};
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      mul_start_r <= 1'b0;
      mul_a_r     <= {WIDTH{1'b0}};
      mul_b_r     <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      id_r        <= id_s;
      timer_r     <= timer_s;
      seen_fin_r  <= seen_fin_s;
      gnt_r       <= gnt_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_id_r    <= rsp_id_s;
      rsp_o_r     <= rsp_o_s;
      rsp_err_r   <= rsp_err_s;
      busy_r      <= busy_s;
      mul_start_r <= mul_start_s;
      mul_a_r     <= mul_a_s;
      mul_b_r     <= mul_b_s;
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_o     = rsp_o_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign mul_start = mul_start_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: transaction-level reference model checked every cycle,
// a behavioural multiplier stub, and directed scenarios with literal expectations.
module tb_mult_share_ctrl;

  localparam int NR = 4;
  localparam int TO = 63;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'd0;
  logic [15:0] req_a = 16'd0;
  logic [15:0] req_b = 16'd0;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_o;
  logic        rsp_err;
  logic        busy;
  logic        mul_start;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_o;
  logic        mul_finish;

  mult_share_ctrl #(.N_REQ(NR), .WIDTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_o(rsp_o),
    .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_o(mul_o), .mul_finish(mul_finish)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gnt_cnt = 0;
  int rsp_cnt = 0;
  int t_start = 0;
  int gnt_log[$];
  int rid_log[$];
  int ro_log[$];
  int rerr_log[$];
  int lat_log[$];
  bit mul_stuck = 1'b0;

  // input snapshot (values the DUT samples at the next rising edge)
  logic        s_rst = 1'b0;
  logic [3:0]  s_req;
  logic [15:0] s_a, s_b;
  logic        s_fin;
  logic [7:0]  s_mo;

  // reference model
  int   m_ptr, m_id, m_t;
  bit   m_busy, m_fin, m_cap;
  logic [3:0] exp_gnt, exp_a, exp_b;
  logic [7:0] exp_o;
  logic [2:0] exp_id;
  logic       exp_rv, exp_err, exp_start, exp_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, req_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_t = 0; m_busy = 1'b0; m_fin = 1'b0; m_cap = 1'b0;
    exp_gnt = 4'd0; exp_a = 4'd0; exp_b = 4'd0; exp_o = 8'd0; exp_id = 3'd0;
    exp_rv = 1'b0; exp_err = 1'b0; exp_start = 1'b0; exp_busy = 1'b0;
  endtask

  // m_t counts edges since the grant edge: edge 1 issues start, edges >=2 are waiting.
  task automatic model_edge();
    int win;
    exp_gnt = 4'd0; exp_start = 1'b0; exp_rv = 1'b0;
    if (!m_busy) begin
      win = -1;
      for (int k = 0; k < NR; k++)
        if (win < 0 && s_req[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      if (win >= 0) begin
        exp_gnt = 4'd1 << win;
        exp_a = s_a[win*4 +: 4];
        exp_b = s_b[win*4 +: 4];
        m_id = win; m_ptr = (win + 1) % NR;
        m_busy = 1'b1; m_t = 0; m_fin = 1'b0; m_cap = 1'b0;
      end
    end else begin
      m_t++;
      if (m_t == 1) exp_start = 1'b1;
      else if (!m_cap) begin
        if (m_fin && !s_fin) begin
          exp_o = s_mo; exp_err = 1'b0; m_cap = 1'b1;
        end else if (m_t == TO + 1) begin
          exp_o = 8'd0; exp_err = 1'b1; m_cap = 1'b1;
        end else if (s_fin) m_fin = 1'b1;
      end else begin
        exp_rv = 1'b1; exp_id = 3'(m_id); m_busy = 1'b0;
      end
    end
    exp_busy = m_busy;
  endtask

  // compare process: advance the model by one edge and check every output
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!s_rst || !reset_n) model_reset();
      else model_edge();
      chk("gnt", gnt, exp_gnt);
      chk("mul_start", mul_start, exp_start);
      chk("mul_a", mul_a, exp_a);
      chk("mul_b", mul_b, exp_b);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_id", rsp_id, exp_id);
      chk("rsp_o", rsp_o, exp_o);
      chk("rsp_err", rsp_err, exp_err);
      chk("busy", busy, exp_busy);
      if (gnt != 4'd0) begin
        for (int i = 0; i < NR; i++) if (gnt[i]) gnt_log.push_back(i);
        gnt_cnt++;
      end
      if (mul_start) t_start = cyc;
      if (rsp_valid) begin
        rid_log.push_back(int'(rsp_id));
        ro_log.push_back(int'(rsp_o));
        rerr_log.push_back(int'(rsp_err));
        lat_log.push_back(cyc - t_start);
        rsp_cnt++;
      end
      cyc++;
      s_rst = reset_n; s_req = req; s_a = req_a; s_b = req_b; s_fin = mul_finish; s_mo = mul_o;
    end
  end

  // multiplier stub: Finish high for two cycles, product presented as Finish falls
  initial begin
    logic [3:0] ma, mb;
    mul_finish = 1'b0;
    mul_o = 8'd0;
    forever begin
      step();
      if (mul_start === 1'b1 && !mul_stuck) begin
        ma = mul_a; mb = mul_b;
        repeat (1 + int'(ma) % 3) step();
        mul_finish = 1'b1; mul_o = 8'hAA;
        repeat (2) step();
        mul_finish = 1'b0; mul_o = {4'd0, ma} * {4'd0, mb};
      end
    end
  end

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
  endtask

  task automatic wait_gnt(input int n);
    int i = 0;
    while (gnt_cnt < n && i < 400) begin step(); i++; end
    chk("gnt_wait", gnt_cnt >= n, 1);
  endtask

  task automatic wait_rsp(input int n);
    int i = 0;
    while (rsp_cnt < n && i < 400) begin step(); i++; end
    chk("rsp_wait", rsp_cnt >= n, 1);
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic run_req(input logic [3:0] r);
    int g, n;
    g = gnt_cnt + 1; n = rsp_cnt + 1;
    req = r;
    wait_gnt(g);
    req = 4'd0;
    wait_rsp(n);
  endtask

  initial begin
    int base, rc;
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base, rc;
    // single request from requester 1: 3*5
    do_reset();
    set_ops(1, 4'd3, 4'd5);
    run_req(4'b0010);
    chk("t1_gnt", gnt_log[gnt_log.size()-1], 1);
    chk("t1_id", rid_log[rid_log.size()-1], 1);
    chk("t1_prod", ro_log[ro_log.size()-1], 15);
    chk("t1_err", rerr_log[rerr_log.size()-1], 0);

    // all four requesting continuously: order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 4'(i + 2), 4'(i + 9));
    base = gnt_cnt;
    req = 4'b1111;
    wait_gnt(base + 5);
    req = 4'd0;
    wait_rsp(base + 5);
    for (int k = 0; k < 5; k++) begin
      chk("rr_gnt", gnt_log[base + k], k % 4);
      chk("rr_id", rid_log[base + k], k % 4);
    end
    chk("rr_p0", ro_log[base], 18);
    chk("rr_p1", ro_log[base + 1], 30);
    chk("rr_p2", ro_log[base + 2], 44);
    chk("rr_p3", ro_log[base + 3], 60);
    chk("rr_p4", ro_log[base + 4], 18);

    // pointer behaviour with req=0101
    do_reset();
    set_ops(0, 4'd1, 4'd7);
    set_ops(2, 4'd2, 4'd4);
    run_req(4'b0101);
    chk("p_first", gnt_log[gnt_log.size()-1], 0);
    run_req(4'b0101);
    chk("p_second", gnt_log[gnt_log.size()-1], 2);
    chk("p_prod", ro_log[ro_log.size()-1], 8);

    // largest operands
    set_ops(3, 4'd15, 4'd15);
    run_req(4'b1000);
    chk("max_prod", ro_log[ro_log.size()-1], 225);
    chk("max_err", rerr_log[rerr_log.size()-1], 0);

    // stuck multiplier: watchdog response, then normal service
    mul_stuck = 1'b1;
    set_ops(0, 4'd5, 4'd5);
    run_req(4'b0001);
    chk("to_err", rerr_log[rerr_log.size()-1], 1);
    chk("to_prod", ro_log[ro_log.size()-1], 0);
    chk("to_lat", lat_log[lat_log.size()-1], 64);
    mul_stuck = 1'b0;
    set_ops(2, 4'd6, 4'd7);
    run_req(4'b0100);
    chk("post_to_prod", ro_log[ro_log.size()-1], 42);
    chk("post_to_err", rerr_log[rerr_log.size()-1], 0);

    // reset while waiting on the multiplier
    mul_stuck = 1'b1;
    set_ops(1, 4'd9, 4'd9);
    req = 4'b0010;
    wait_gnt(gnt_cnt + 1);
    req = 4'd0;
    repeat (4) step();
    rc = rsp_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_gnt", gnt, 0);
    chk("ar_rv", rsp_valid, 0);
    chk("ar_id", rsp_id, 0);
    chk("ar_o", rsp_o, 0);
    chk("ar_err", rsp_err, 0);
    chk("ar_busy", busy, 0);
    chk("ar_start", mul_start, 0);
    chk("ar_a", mul_a, 0);
    chk("ar_b", mul_b, 0);
    repeat (6) step();
    mul_stuck = 1'b0;
    set_ops(2, 4'd2, 4'd3);
    set_ops(3, 4'd4, 4'd4);
    req = 4'b1100;
    reset_n = 1'b1;
    wait_gnt(gnt_cnt + 1);
    req = 4'd0;
    wait_rsp(rc + 1);
    chk("ar_first_gnt", gnt_log[gnt_log.size()-1], 2);
    chk("ar_no_drop_rsp", rsp_cnt, rc + 1);
    chk("ar_prod", ro_log[ro_log.size()-1], 6);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
